// File: rtl/factoradic_pkg.sv
// Width/offset helpers for the packed factoradic digit vector (digit i holds 0..i).
package factoradic_pkg;

    localparam int unsigned VEC_W = 64;
    typedef logic [VEC_W-1:0] vec_t;

    function automatic int unsigned dig_w(input int unsigned i);
        return $clog2(i + 1);
    endfunction

    function automatic int unsigned dig_ofs(input int unsigned i);
        int unsigned s = 0;
        for (int unsigned k = 1; k < i; k++) s += dig_w(k);
        return s;
    endfunction

    function automatic int unsigned total_w(input int unsigned n);
        return dig_ofs(n + 1);
    endfunction

    function automatic vec_t max_vec(input int unsigned n);
        vec_t v = '0;
        for (int unsigned k = 1; k <= n; k++) v |= vec_t'(k) << dig_ofs(k);
        return v;
    endfunction

endpackage

// File: rtl/factoradic_digit.sv
// One factoradic digit of range 0..I: next value and ripple carry/borrow.
module factoradic_digit
    import factoradic_pkg::*;
#(
    parameter  int unsigned I  = 1,
    localparam int unsigned DW = dig_w(I)
) (
    input  logic [DW-1:0] value,
    input  logic          carry_in,
    input  logic          up,
    input  logic          en,
    output logic [DW-1:0] next,
    output logic          carry_out
);

    localparam logic [DW-1:0] TOP = DW'(I);

    logic at_top;
    logic at_bot;

    assign at_top    = (value == TOP);
    assign at_bot    = (value == '0);
    assign carry_out = carry_in & (up ? at_top : at_bot);

    always_comb begin
        next = value;
        if (en && carry_in) begin
            if (up) next = at_top ? '0 : value + DW'(1);
            else    next = at_bot ? TOP : value - DW'(1);
        end
    end

endmodule

// File: rtl/factoradic_counter.sv
// Registered N-digit factoradic up/down counter with clamped load and wrap flag.
// Define FACTCNT_LOAD_CHECK_EN to add the registered load_err output.
module factoradic_counter
    import factoradic_pkg::*;
#(
    parameter  int unsigned N = 7,
    localparam int unsigned W = total_w(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         at_max,
    output logic         at_zero
`ifdef FACTCNT_LOAD_CHECK_EN
    ,
    output logic         load_err
`endif
);

    localparam vec_t MAXV = max_vec(N);

    logic [N:0]   carry;
    logic [W-1:0] next_count;
    logic [W-1:0] clamped;
`ifdef FACTCNT_LOAD_CHECK_EN
    logic [N-1:0] over;
`endif

    assign carry[0] = 1'b1;

    for (genvar g = 1; g <= N; g++) begin : g_dig
        localparam int unsigned DW  = dig_w(g);
        localparam int unsigned OFS = dig_ofs(g);
        localparam logic [DW-1:0] TOP = DW'(g);

        logic [DW-1:0] ld;
        assign ld = load_val[OFS +: DW];
        assign clamped[OFS +: DW] = (ld > TOP) ? TOP : ld;
`ifdef FACTCNT_LOAD_CHECK_EN
        assign over[g-1] = (ld > TOP);
`endif

        factoradic_digit #(.I(g)) u_digit (
            .value    (count[OFS +: DW]),
            .carry_in (carry[g-1]),
            .up       (up),
            .en       (en),
            .next     (next_count[OFS +: DW]),
            .carry_out(carry[g])
        );
    end

    // carry[N] set means every digit sat at its max (up) or zero (down): a wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
`ifdef FACTCNT_LOAD_CHECK_EN
            load_err <= 1'b0;
`endif
        end else if (load) begin
            count <= clamped;
            wrap  <= 1'b0;
`ifdef FACTCNT_LOAD_CHECK_EN
            load_err <= |over;
`endif
        end else begin
            if (en) count <= next_count;
            wrap <= en & carry[N];
`ifdef FACTCNT_LOAD_CHECK_EN
            load_err <= 1'b0;
`endif
        end
    end

    assign at_zero = (count == '0);
    assign at_max  = (count == MAXV[W-1:0]);

endmodule
